// File: rtl/mux8to1_rr_arbiter_if.sv
// Arbiter <-> requester bundle for mux8to1_rr_arbiter: request vector in,
// one-hot grant plus mux select/enable out.
interface mux8to1_rr_arbiter_if;
   localparam int unsigned NREQ_W = 8;
   localparam int unsigned SEL_W  = 3;

   logic [NREQ_W-1:0] req;
   logic [NREQ_W-1:0] gnt;
   logic [SEL_W-1:0]  sel;
   logic              en;
   logic              busy;

   modport master (input req, output gnt, output sel, output en, output busy);
   modport slave  (output req, input gnt, input sel, input en, input busy);
endinterface

// File: rtl/mux8to1_rr_arbiter.sv
// Round-robin arbiter driving the sel/en of a shared 8:1 mux.
// Optional per-owner hold cap enabled by defining MUX_ARB_HOLD_LIMIT_EN.
module mux8to1_rr_arbiter #(
   parameter int unsigned NREQ     = 8,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mux8to1_rr_arbiter_if.master  arb_if
);
   localparam int unsigned SEL_W  = 3;
   localparam int unsigned HOLD_W = 8;

   if (NREQ != 8) begin : g_bad_nreq
      $fatal(1, "mux8to1_rr_arbiter: NREQ must be 8");
   end
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $fatal(1, "mux8to1_rr_arbiter: MAX_HOLD must be in 2..255");
   end

   typedef enum logic {ST_IDLE, ST_GRANT} state_e;

   state_e             state_q, state_d;
   logic [NREQ-1:0]    gnt_q, gnt_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [SEL_W-1:0]   last_q, last_d;

   // First asserted bit of vec searched from base+1 upwards, wrapping.
   function automatic logic [SEL_W-1:0] first_req(input logic [NREQ-1:0] vec,
                                                  input logic [SEL_W-1:0] base);
      logic [SEL_W-1:0] idx;
      first_req = base;
      for (int k = 8; k >= 1; k--) begin
         idx = SEL_W'(int'(base) + k);
         if (vec[idx]) first_req = idx;
      end
   endfunction

   logic [NREQ-1:0]  req;
   logic [NREQ-1:0]  req_others;
   logic [SEL_W-1:0] win_any;
   logic [SEL_W-1:0] win_others;

   assign req        = arb_if.req;
   assign req_others = req & ~(NREQ'(1) << sel_q);
   assign win_any    = first_req(req, last_q);
   assign win_others = first_req(req_others, sel_q);

`ifdef MUX_ARB_HOLD_LIMIT_EN
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      hold_cnt_d = hold_cnt_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            gnt_d = '0;
            if (|req) begin
               state_d = ST_GRANT;
               gnt_d   = NREQ'(1) << win_any;
               sel_d   = win_any;
               last_d  = win_any;
`ifdef MUX_ARB_HOLD_LIMIT_EN
               hold_cnt_d = '0;
`endif
            end
         end
         ST_GRANT: begin
            if (req[sel_q]) begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
               // Owner has used its quota and someone else is waiting: rotate.
               if (hold_cnt_q == HOLD_MAX && |req_others) begin
                  gnt_d      = NREQ'(1) << win_others;
                  sel_d      = win_others;
                  last_d     = win_others;
                  hold_cnt_d = '0;
               end else if (hold_cnt_q != HOLD_MAX) begin
                  hold_cnt_d = hold_cnt_q + HOLD_W'(1);
               end
`endif
            end else if (|req) begin
               gnt_d  = NREQ'(1) << win_any;
               sel_d  = win_any;
               last_d = win_any;
`ifdef MUX_ARB_HOLD_LIMIT_EN
               hold_cnt_d = '0;
`endif
            end else begin
               state_d = ST_IDLE;
               gnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         last_q  <= SEL_W'(7);
`ifdef MUX_ARB_HOLD_LIMIT_EN
         hold_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
`ifdef MUX_ARB_HOLD_LIMIT_EN
         hold_cnt_q <= hold_cnt_d;
`endif
      end
   end

   assign arb_if.gnt  = gnt_q;
   assign arb_if.sel  = sel_q;
   assign arb_if.en   = (state_q == ST_GRANT);
   assign arb_if.busy = (state_q == ST_GRANT);
endmodule
